// File: rtl/lut_cfg_pkg.sv
// Shared definitions for the runtime-loadable truth-table neuron:
// controller states and table geometry derived from the parameters.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_e;

    function automatic int lut_depth(input int in_bits);
        return 1 << in_bits;
    endfunction

    function automatic int lut_nbeats(input int in_bits, input int out_bits, input int cfg_w);
        return (lut_depth(in_bits) * out_bits) / cfg_w;
    endfunction

    // Beat counter width, never narrower than one bit.
    function automatic int lut_beat_w(input int in_bits, input int out_bits, input int cfg_w);
        int nb;
        nb = lut_nbeats(in_bits, out_bits, cfg_w);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// DEPTH x OUT_BITS distributed table: one config beat (CFG_W/OUT_BITS entries)
// written per clock, asynchronous single-entry read.
module lut_table_ram
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8,
    localparam int BEAT_W  = lut_beat_w(IN_BITS, OUT_BITS, CFG_W)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [BEAT_W-1:0]   wbeat,
    input  logic [CFG_W-1:0]    wdata,
    input  logic [IN_BITS-1:0]  raddr,
    output logic [OUT_BITS-1:0] rdata
);
    localparam int TBITS = lut_depth(IN_BITS) * OUT_BITS;
    localparam int TAW   = $clog2(TBITS);

    // Stored flat: entry e occupies bits [e*OUT_BITS +: OUT_BITS], so beat k
    // lands contiguously at [k*CFG_W +: CFG_W] with its LSB entry first.
    logic [TBITS-1:0] mem;
    logic [TAW-1:0]   wbase;
    logic [TAW-1:0]   rbase;

    assign wbase = TAW'(wbeat * CFG_W);
    assign rbase = TAW'(raddr * OUT_BITS);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wbase +: CFG_W] <= wdata;
        end
    end

    assign rdata = mem[rbase +: OUT_BITS];

endmodule

// File: rtl/lut_neuron_cfg_loader.sv
// Runtime-programmable truth-table neuron: streams a packed table in over a
// valid/ready config port, then serves lookups through one registered stage.
module lut_neuron_cfg_loader
    import lut_cfg_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int CFG_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                load_done,
    output logic                table_valid,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data
);
    localparam int NBEATS = lut_nbeats(IN_BITS, OUT_BITS, CFG_W);
    localparam int BEAT_W = lut_beat_w(IN_BITS, OUT_BITS, CFG_W);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    state_e              state;
    state_e              state_nxt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                beat_acc;
    logic                last_beat;
    logic                lookup_acc;
    logic [OUT_BITS-1:0] rd_p0;
    logic [OUT_BITS-1:0] data_p1;
    logic                vld_p1;
    logic                done_p1;

    assign cfg_ready   = (state == LOAD);
    assign table_valid = (state == READY);
    assign beat_acc    = cfg_valid && cfg_ready;
    assign last_beat   = beat_acc && (beat_cnt == LAST_BEAT);
    assign in_ready    = (state == READY) && (!vld_p1 || out_ready);
    assign lookup_acc  = in_valid && in_ready;

    // A reload can only start from EMPTY or READY; a load always runs to completion.
    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY:   if (cfg_start) state_nxt = LOAD;
            LOAD:    if (last_beat) state_nxt = READY;
            READY:   if (cfg_start) state_nxt = LOAD;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            beat_cnt <= '0;
            done_p1  <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_p1 <= last_beat;
            if (beat_acc) begin
                beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // p0: table read at the requested address (writes only happen in LOAD,
    // so a lookup accepted alongside cfg_start sees the old table)
    lut_table_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_W    (CFG_W)
    ) u_ram (
        .clk   (clk),
        .we    (beat_acc),
        .wbeat (beat_cnt),
        .wdata (cfg_data),
        .raddr (in_data),
        .rdata (rd_p0)
    );

    // p1: output register, held while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (lookup_acc) begin
            vld_p1  <= 1'b1;
            data_p1 <= rd_p0;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign load_done = done_p1;

endmodule

// File: doc/lut_neuron_cfg_loader.md
Name: lut_neuron_cfg_loader

Overview:
Runtime-programmable truth-table neuron with a streaming configuration writer. It accepts a packed truth table over a valid/ready config stream and stores it in a 2^IN_BITS x OUT_BITS distributed table. Once loaded, it answers lookups through a registered, back-pressured pipeline stage. It is the load-side counterpart of the fixed-ROM layer neurons, used for field-updatable layers and for bring-up without resynthesis.

Parameters:
IN_BITS, 8, lookup address width; table depth DEPTH = 2^IN_BITS
OUT_BITS, 1, width of each table entry
CFG_W, 8, config beat width; DEPTH*OUT_BITS must be a multiple of CFG_W, with NBEATS = DEPTH*OUT_BITS/CFG_W (32 at defaults)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  pulse; begins a (re)load, valid only while cfg_ready=0 and state!=LOAD
cfg_valid  in  1  config beat valid
cfg_ready  out  1  config beat accepted when cfg_valid&&cfg_ready
cfg_data  in  CFG_W  packed table bits, LSB first
load_done  out  1  one-cycle pulse after the last beat is written
table_valid  out  1  table holds a complete load
in_valid  in  1  lookup request valid
in_ready  out  1  lookup accepted when in_valid&&in_ready
in_data  in  IN_BITS  lookup address
out_valid  out  1  lookup result valid
out_ready  in  1  downstream accepts result
out_data  out  OUT_BITS  table entry at the accepted address

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=EMPTY, beat_cnt=0, cfg_ready=0, load_done=0, table_valid=0, out_valid=0, out_data=0. Table contents are not reset.
- States: EMPTY -> LOAD on cfg_start. LOAD -> READY after beat NBEATS-1 is accepted. READY -> LOAD on cfg_start. No other transitions.
- LOAD: cfg_ready=1, table_valid=0. Each accepted beat k writes cfg_data[j*OUT_BITS +: OUT_BITS] to entry k*(CFG_W/OUT_BITS)+j. beat_cnt increments modulo NBEATS. On the last beat, load_done pulses in the next cycle, table_valid rises in that same cycle, and the state goes to READY.
- cfg_start during LOAD is ignored. A load is never aborted except by rst_n. cfg_valid outside LOAD is dropped (cfg_ready=0).
- in_ready = (state==READY) && (!out_valid || out_ready).
- On an accepted lookup, out_data <= table[in_data] and out_valid <= 1 at the next edge (latency 1 cycle).
- out_valid clears on out_ready when there is no new accept. Accept and drain in the same cycle gives full throughput (1 lookup/cycle).
- out_data and out_valid hold stable while out_valid && !out_ready, including across an entry into LOAD.
- cfg_start and an accepted lookup in the same cycle: the lookup uses the pre-reload table, and in_ready=0 from the next cycle.
- Reset mid-LOAD: return to EMPTY, table_valid=0. The partial table is treated as garbage.
- in_valid while not READY: held off by in_ready=0, never dropped silently.

Decomposition:
- Shared package lut_cfg_pkg: state enum {EMPTY, LOAD, READY}, and the DEPTH and NBEATS derivation functions.
- One sub-module, lut_table_ram: a DEPTH x OUT_BITS distributed RAM with a CFG_W/OUT_BITS-entry write port and an asynchronous read port. The output register lives in the top level.

Test Plan:
1. Reset, then hold in_valid=1 with in_data=8'h00 -> in_ready=0, out_valid=0, table_valid=0 for 20 cycles.
2. cfg_start, then 32 back-to-back beats of 8'hA5 -> load_done pulses once, 1 cycle after beat 31. table_valid=1. Lookups 8'h05->1, 8'h03->0, 8'h27->1, 8'hFE->0, each with out_valid 1 cycle after accept.
3. Stream 256 consecutive lookups with out_ready toggling 1010... -> no lost or duplicated results, order preserved, out_data stable while stalled.
4. With out_valid=1 and out_ready=0, pulse cfg_start and reload with 32 beats of 8'h00 -> the held result is unchanged until drained. Afterwards lookup 8'h05 -> 0.
5. Insert cfg_valid gaps (beat every third cycle) and a cfg_start pulse mid-LOAD -> exactly 32 beats are consumed, and the second cfg_start has no effect.
6. Assert rst_n=0 after beat 10 of a load -> immediate EMPTY, cfg_ready=0, table_valid=0. A following full load of 8'hFF gives lookup 8'h3C -> 1.
